ffbank_zinit: RTL

Parametrised multi-channel flip-flop bank that generalises the single-bit async-clear, preset and enable flop primitives into CHANNELS independent WIDTH-bit registers. Each register has a defined power-up value, a shared asynchronous clear, a per-channel asynchronous preset, a per-channel load enable, a bank-wide serial scan chain for readback and preload, and sticky per-channel change flags. The block is the reference flop-bank used in init-value and async-reset mapping regression designs.

---
 rtl/ffbank_zinit.sv | 67 ++++++
 1 files changed

// File: rtl/ffbank_zinit.sv
// Multi-channel flop bank with async clear, per-channel async preset,
// load enable, bank-wide scan chain and sticky per-channel change flags.
module ffbank_zinit #(
    parameter int                 WIDTH    = 8,
    parameter int                 CHANNELS = 4,
    parameter logic [WIDTH-1:0]   RST_VAL  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0]   SET_VAL  = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]   INIT_VAL = {WIDTH{1'b0}}
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [CHANNELS-1:0]       pre,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic                      scan_en,
    input  logic                      scan_in,
    output logic                      scan_out,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       chg,
    input  logic                      chg_clr
);
    localparam int N = CHANNELS * WIDTH;

    // Extended vector keeps the shift slice legal even when N == 1.
    logic [N:0]   w_ext;
    logic [N-1:0] w_shift;

    assign w_ext    = {q, scan_in};
    assign w_shift  = w_ext[N-1:0];
    assign scan_out = q[N-1];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] r_q   = INIT_VAL;
        logic             r_chg = 1'b0;
        logic [WIDTH-1:0] w_d;
        logic             w_ld_chg;

        assign w_d      = d[i*WIDTH +: WIDTH];
        assign w_ld_chg = !scan_en && en[i] && (w_d != r_q);

        always_ff @(posedge clk or posedge clr or posedge pre[i]) begin
            if (clr) begin
                r_q <= RST_VAL;
            end else if (pre[i]) begin
                r_q <= SET_VAL;
            end else if (scan_en) begin
                r_q <= w_shift[i*WIDTH +: WIDTH];
            end else if (en[i]) begin
                r_q <= w_d;
            end
        end

        // A same-cycle change wins over chg_clr.
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                r_chg <= 1'b0;
            end else if (w_ld_chg && !pre[i]) begin
                r_chg <= 1'b1;
            end else if (chg_clr) begin
                r_chg <= 1'b0;
            end
        end

        assign q[i*WIDTH +: WIDTH] = r_q;
        assign chg[i]              = r_chg;
    end
endmodule
